// File: rtl/muldiv_pkg.sv
// Shared constants, state encoding and operand-sign helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;
  localparam logic [5:0]  ITER  = 6'd32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  function automatic logic a_is_signed(input logic [2:0] f);
    return (f == F3_MUL) || (f == F3_MULH) || (f == F3_MULHSU) ||
           (f == F3_DIV) || (f == F3_REM);
  endfunction

  function automatic logic b_is_signed(input logic [2:0] f);
    return (f == F3_MUL) || (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One radix-2 step per cycle: shift-add multiply or restoring divide on unsigned magnitudes.
module muldiv_iter_core
  import muldiv_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                step,
  input  logic                div_mode,
  input  logic [XLEN-1:0]     a_mag,
  input  logic [XLEN-1:0]     b_mag,
  output logic [2*XLEN-1:0]   acc
);

  logic [XLEN-1:0] opnd;
  logic            mode_q;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   trial;

  // Multiply keeps the multiplier in acc[31:0]; divide keeps remainder:quotient in acc.
  always_comb begin
    sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
    trial = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      opnd   <= '0;
      mode_q <= 1'b0;
    end else if (load) begin
      mode_q <= div_mode;
      opnd   <= div_mode ? b_mag : a_mag;
      acc    <= {XLEN'(0), (div_mode ? a_mag : b_mag)};
    end else if (step) begin
      if (mode_q) begin
        if (!trial[XLEN]) acc <= {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else              acc <= {acc[2*XLEN-2:0], 1'b0};
      end else begin
        if (acc[0]) acc <= {sum, acc[XLEN-1:1]};
        else        acc <= {1'b0, acc[2*XLEN-1:1]};
      end
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative RV32M unit: control FSM, sign handling, special cases and result register.
module ex_muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall_req,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        f3_q;
  logic              res_neg;
  logic              rem_neg;

  logic              sign_a, sign_b;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_val;
  logic [XLEN-1:0]   fix_val;
  logic [2*XLEN-1:0] acc, mul_p;
  logic [XLEN-1:0]   quo_s, rem_s;
  logic              load, step;

  // Operand signs, magnitudes and early-out detection, evaluated on the live inputs.
  always_comb begin
    sign_a      = a_is_signed(funct3) & op_a[XLEN-1];
    sign_b      = b_is_signed(funct3) & op_b[XLEN-1];
    a_mag       = sign_a ? XLEN'(-op_a) : op_a;
    b_mag       = sign_b ? XLEN'(-op_b) : op_b;
    div_zero    = funct3[2] && (op_b == '0);
    div_ovf     = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                  (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    special     = div_zero || div_ovf;
    special_val = '0;
    if (div_zero)     special_val = funct3[1] ? op_a : '1;
    else if (div_ovf) special_val = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  assign load = (state == IDLE) && start && !flush && !special;
  assign step = (state == CALC) && !flush;

  muldiv_iter_core u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .div_mode (funct3[2]),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .acc      (acc)
  );

  // Sign fix-up and result selection applied in FIX.
  always_comb begin
    mul_p = res_neg ? (2*XLEN)'(-acc) : acc;
    quo_s = res_neg ? XLEN'(-acc[XLEN-1:0]) : acc[XLEN-1:0];
    rem_s = rem_neg ? XLEN'(-acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];
    case (f3_q)
      F3_MUL:                       fix_val = mul_p[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_val = mul_p[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              fix_val = quo_s;
      default:                      fix_val = rem_s;
    endcase
  end

  assign stall_req = ((state == IDLE) && start && !flush) ||
                     (state == CALC) || (state == FIX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      f3_q    <= '0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            f3_q    <= funct3;
            res_neg <= sign_a ^ sign_b;
            rem_neg <= sign_a;
            cnt     <= '0;
            busy    <= 1'b1;
            if (special) begin
              result <= special_val;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(ITER - 6'd1)) begin
            cnt   <= '0;
            state <= FIX;
          end
        end
        FIX: begin
          result <= fix_val;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed and random ops against a plain-arithmetic model.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic        stall_req, busy, done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int stall_busy_cnt = 0;
  logic [31:0] last_res = '0;
  logic        prev_done = 1'b0;

  logic [31:0] exp_q[$];
  int          due_q[$];

  ex_muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .stall_req(stall_req), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model straight from the RV32M definitions.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, q;
    logic [63:0] p;
    sa = longint'({{32{a[31]}}, a});
    sb = longint'({{32{b[31]}}, b});
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sa / sb; p = q; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        q = ua / ub; p = q; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = sa % sb; p = q; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        q = ua % ub; p = q; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return (f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  // Called at a negedge; start is sampled at the following posedge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit scored);
    int lat;
    lat = is_special(f, a, b) ? 0 : 33;
    start = 1'b1; funct3 = f; op_a = a; op_b = b;
    if (scored) begin
      exp_q.push_back(exp);
      due_q.push_back(cyc + 1 + lat);
    end
    @(posedge clk); #1;
    start = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 200);
    if (busy) chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp);
    issue(f, a, b, exp, 1'b1);
    wait_idle();
  endtask

  // Monitor: pops expectations whenever the DUT presents done.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && stall_req) stall_busy_cnt++;
      if (prev_done) begin
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("done_one_cycle", 64'(done), 64'd0);
      end
      if (done) begin
        chk("stall_low_in_done", 64'(stall_req), 64'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          logic [31:0] e;
          int d;
          e = exp_q.pop_front();
          d = due_q.pop_front();
          chk("result", 64'(result), 64'(e));
          chk("latency", 64'(cyc), 64'(d));
          last_res = e;
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    rst = 1'b1; start = 1'b0; funct3 = 3'd0; op_a = '0; op_b = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_stall", 64'(stall_req), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases with hand-computed answers.
    stall_busy_cnt = 0;
    run(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    chk("mul_stall_cycles", 64'(stall_busy_cnt), 64'd33);
    run(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    run(3'd4, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2);
    run(3'd6, 32'd100, 32'hFFFF_FFF9, 32'h0000_0002);
    run(3'd5, 32'd100, 32'd7, 32'd14);
    run(3'd7, 32'd100, 32'd7, 32'd2);
    run(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run(3'd6, 32'd5, 32'd0, 32'd5);
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

    // Flush ten cycles into a DIV: nothing completes, result holds.
    issue(3'd4, 32'd1000, 32'd3, 32'd0, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_stall", 64'(stall_req), 64'd0);
    chk("flush_result_held", 64'(result), 64'(last_res));
    run(3'd0, 32'd12345, 32'd678, 32'd8369910);

    // flush together with start in IDLE starts nothing.
    start = 1'b1; flush = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_start_busy", 64'(busy), 64'd0);
    chk("flush_start_result", 64'(result), 64'(last_res));

    // Reset in the middle of CALC clears everything.
    issue(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    chk("midrst_stall", 64'(stall_req), 64'd0);
    rst = 1'b0;
    last_res = '0;
    @(negedge clk);

    // Random ops, back-to-back or with short gaps, including edge operands.
    for (int i = 0; i < 48; i++) begin
      f = 3'($urandom);
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      run(f, a, b, model(f, a, b));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the rs1/rs2 forwarding muxes. It takes the already-forwarded operands and the M-extension funct3 and computes the result over multiple cycles. While it works, it holds the pipeline through a stall request, then presents a registered result for one cycle so the instruction can advance to MEM.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  EX holds a valid M-extension instruction; sampled only in IDLE.
- funct3  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  XLEN  forwarded rs1 value (forward mux A output).
- op_b  input  XLEN  forwarded rs2 value (forward mux B output).
- flush  input  1  kill the in-flight operation (branch mispredict/trap).
- stall_req  output  1  hold PC, IF/ID and ID/EX; combinational.
- busy  output  1  state is not IDLE; registered.
- done  output  1  result valid, one-cycle pulse; registered.
- result  output  XLEN  operation result; registered, holds until the next load.

## Operation
- States and transitions:
  - IDLE: if start, go to CALC.
  - CALC: runs 32 iterations, counter 0..31; after iteration 31, go to FIX.
  - FIX: go to DONE.
  - DONE: go to IDLE.
- Reset or flush in any state returns to IDLE.
- Start latching:
  - On start in IDLE, latch funct3, the magnitudes of op_a and op_b, and the result sign.
  - Later operand changes are ignored.
- Signedness:
  - MUL, MULH, DIV and REM treat both operands as signed.
  - MULHSU treats op_a as signed and op_b as unsigned.
  - MULHU, DIVU and REMU treat both operands as unsigned.
- Multiply:
  - Radix-2 shift-add on magnitudes into a 64-bit accumulator.
  - In FIX, negate the product if the sign is negative.
  - MUL returns bits [31:0]; the others return bits [63:32].
- Divide:
  - Restoring division on magnitudes.
  - Quotient sign is sign(a) XOR sign(b). Remainder sign is sign(a).
  - Signs are applied in FIX.
- Special cases are resolved in IDLE on start and skip CALC/FIX, going straight to DONE:
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return op_a.
  - Signed overflow (op_a = 0x80000000, op_b = 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- stall_req = (IDLE & start & ~flush) | CALC | FIX. It is low in DONE so EX advances with the result.
- Priority: rst > flush > start. start outside IDLE is ignored.
- Reset values: state IDLE, counter 0, busy 0, done 0, result 0, stall_req 0.

## Timing
- Normal op: start sampled at edge E0.
  - CALC occupies edges E1..E32.
  - FIX result registered at E33.
  - done=1 during the cycle after E33; latency is 34 cycles.
  - All MUL variants take the same latency; there is no early termination.
- Special case: start sampled at E0, done=1 the cycle after E0.
- done is high for exactly one cycle. busy is low in the cycle after done.
- Back-to-back: a new start is accepted in the IDLE cycle following DONE; there is no dead cycle beyond that.
- flush:
  - Takes effect at the next edge: state IDLE and done never asserted for the killed op.
  - result keeps its previous value.
  - flush together with start in IDLE starts nothing.
- rst mid-operation behaves as flush and also clears result.

## Structure
- Package muldiv_pkg holds:
  - XLEN;
  - the funct3 localparams (F3_MUL..F3_REMU);
  - the state enum (IDLE, CALC, FIX, DONE);
  - a 6-bit iteration-count constant ITER = 32.
- One sub-module, muldiv_iter_core: the per-iteration shift-add / restore-subtract datapath (accumulator, partial remainder, quotient shift).
- FSM, sign handling and special cases stay in ex_muldiv_unit.

## Test plan
- MUL, op_a=7, op_b=0xFFFFFFFD (-3) -> result 0xFFFFFFEB; done exactly 34 cycles after start; stall_req high for 33 cycles.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- Signed divide 100 by 0xFFFFFFF9 (-7): DIV -> 0xFFFFFFF2 (-14), REM -> 0x00000002. DIVU 100/7 -> 14, REMU -> 2.
- Divide by zero: DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each with done one cycle after start.
- Signed overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, with 1-cycle latency.
- flush asserted 10 cycles into a DIV -> IDLE next edge, no done pulse, result unchanged. A new MUL started the following cycle completes correctly. rst mid-CALC -> all outputs 0.
